// File: rtl/zbreak.sv
// Z80 address-breakpoint unit: matches M1 fetch addresses against bp_addr and pulses brk_req toward the NMI generator.
// Optional write-address breakpoints are built in when ZBREAK_WR_EN is defined.
module zbreak #(
  parameter int REQ_LEN   = 4,
  parameter int LOST_INTS = 2
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic        zneg,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        wr_n,
  input  logic [15:0] a,
  input  logic        int_start,
  input  logic        in_nmi,
  input  logic [7:0]  din,
  input  logic        wr_bplo,
  input  logic        wr_bphi,
  input  logic        wr_pass,
  input  logic        wr_ctrl,
  output logic        brk_req,
  output logic [7:0]  status
);

  // state     | meaning
  // IDLE      | disabled or finished, waiting for an enable write
  // ARMED     | comparing bus events against bp_addr
  // REQ       | driving the brk_req pulse (not abortable)
  // WAIT_NMI  | waiting for the generator to open an NMI session
  // WAIT_EXIT | NMI session running, waiting for it to end
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT_NMI  = 3'd3,
    S_WAIT_EXIT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bp_q, bp_d;
  logic [7:0]  pass_rld_q, pass_rld_d;
  logic [7:0]  pass_cnt_q, pass_cnt_d;
  logic [3:0]  req_cnt_q, req_cnt_d;
  logic [7:0]  int_cnt_q, int_cnt_d;
  logic        enable_q, enable_d;
  logic        autore_q, autore_d;
  logic        wbrk_q, wbrk_d;
  logic        hit_q, hit_d;
  logic        lost_q, lost_d;
  logic        brk_req_q, brk_req_d;
  logic        m1_q, m1_d;
  logic        mreq_q, mreq_d;
  logic        was_m1_q, was_m1_d;
  logic        fetch_ev;
  logic        match_ev;
  logic        ctrl_on, ctrl_off;

`ifdef ZBREAK_WR_EN
  logic wrn_q, wrn_d;
  logic was_wr_q, was_wr_d;
  logic wr_ev;

  always_comb begin
    wrn_d    = zneg ? wr_n : wrn_q;
    was_wr_d = ~mreq_q & ~wrn_q;
    wr_ev    = was_wr_d & ~was_wr_q;
    match_ev = wbrk_q ? wr_ev : fetch_ev;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wrn_q    <= 1'b1;
      was_wr_q <= 1'b0;
    end else begin
      wrn_q    <= wrn_d;
      was_wr_q <= was_wr_d;
    end
  end
`else
  logic unused_wr_n;
  assign unused_wr_n = wr_n;
  assign match_ev    = fetch_ev;
`endif

  // Both strobes are sampled at their own Z80 edge; the event is the first fclk both read low.
  always_comb begin
    m1_d     = zpos ? m1_n : m1_q;
    mreq_d   = zneg ? mreq_n : mreq_q;
    was_m1_d = ~m1_q & ~mreq_q;
    fetch_ev = was_m1_d & ~was_m1_q;
  end

  assign ctrl_on  = wr_ctrl & din[0];
  assign ctrl_off = wr_ctrl & ~din[0];

  always_comb begin
    state_d    = state_q;
    bp_d       = bp_q;
    pass_rld_d = pass_rld_q;
    pass_cnt_d = pass_cnt_q;
    req_cnt_d  = req_cnt_q;
    int_cnt_d  = int_cnt_q;
    enable_d   = enable_q;
    autore_d   = autore_q;
    wbrk_d     = wbrk_q;
    hit_d      = hit_q;
    lost_d     = lost_q;
    brk_req_d  = 1'b0;

    if (wr_bplo) bp_d[7:0]  = din;
    if (wr_bphi) bp_d[15:8] = din;
    if (wr_pass) pass_rld_d = din;
    if (wr_ctrl) begin
      enable_d = din[0];
      autore_d = din[1];
`ifdef ZBREAK_WR_EN
      wbrk_d   = din[2];
`else
      wbrk_d   = 1'b0;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_on) begin
          pass_cnt_d = pass_rld_q;
          hit_d      = 1'b0;
          lost_d     = 1'b0;
          state_d    = S_ARMED;
        end
      end
      S_ARMED: begin
        if (ctrl_off) begin
          state_d = S_IDLE;
        end else if (match_ev && (a == bp_q) && !in_nmi) begin
          if (pass_cnt_q != 8'd0) begin
            pass_cnt_d = pass_cnt_q - 8'd1;
          end else begin
            hit_d     = 1'b1;
            brk_req_d = 1'b1;
            req_cnt_d = 4'(REQ_LEN - 1);
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A disable seen during the pulse is honoured only once the pulse is over.
        if (req_cnt_q == 4'd0) begin
          int_cnt_d = 8'(LOST_INTS - 1);
          state_d   = enable_d ? S_WAIT_NMI : S_IDLE;
        end else begin
          req_cnt_d = req_cnt_q - 4'd1;
          brk_req_d = 1'b1;
        end
      end
      S_WAIT_NMI: begin
        if (ctrl_off) begin
          state_d = S_IDLE;
        end else if (in_nmi) begin
          state_d = S_WAIT_EXIT;
        end else if (int_start) begin
          if (int_cnt_q == 8'd0) begin
            lost_d  = 1'b1;
            state_d = autore_q ? S_ARMED : S_IDLE;
          end else begin
            int_cnt_d = int_cnt_q - 8'd1;
          end
        end
      end
      S_WAIT_EXIT: begin
        if (ctrl_off) begin
          state_d = S_IDLE;
        end else if (!in_nmi) begin
          if (autore_q) begin
            pass_cnt_d = pass_rld_q;
            state_d    = S_ARMED;
          end else begin
            enable_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bp_q       <= 16'h0000;
      pass_rld_q <= 8'h00;
      pass_cnt_q <= 8'h00;
      req_cnt_q  <= 4'd0;
      int_cnt_q  <= 8'd0;
      enable_q   <= 1'b0;
      autore_q   <= 1'b0;
      wbrk_q     <= 1'b0;
      hit_q      <= 1'b0;
      lost_q     <= 1'b0;
      brk_req_q  <= 1'b0;
      m1_q       <= 1'b1;
      mreq_q     <= 1'b1;
      was_m1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bp_q       <= bp_d;
      pass_rld_q <= pass_rld_d;
      pass_cnt_q <= pass_cnt_d;
      req_cnt_q  <= req_cnt_d;
      int_cnt_q  <= int_cnt_d;
      enable_q   <= enable_d;
      autore_q   <= autore_d;
      wbrk_q     <= wbrk_d;
      hit_q      <= hit_d;
      lost_q     <= lost_d;
      brk_req_q  <= brk_req_d;
      m1_q       <= m1_d;
      mreq_q     <= mreq_d;
      was_m1_q   <= was_m1_d;
    end
  end

  assign brk_req = brk_req_q;
  assign status  = {enable_q, autore_q, hit_q, lost_q, wbrk_q, state_q};

endmodule

// File: tb/tb_zbreak.sv
// Testbench for zbreak: register/status vector table plus hand sequences for hits, sessions and resets.
// brk_req pulses are checked against a queue of expected pulse widths.
module tb_zbreak;
  localparam int REQ_LEN = 4;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        zpos = 1'b0, zneg = 1'b0;
  logic        m1_n = 1'b1, mreq_n = 1'b1, wr_n = 1'b1;
  logic [15:0] a = 16'h0000;
  logic        int_start = 1'b0, in_nmi = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        wr_bplo = 1'b0, wr_bphi = 1'b0, wr_pass = 1'b0, wr_ctrl = 1'b0;
  logic        brk_req;
  logic [7:0]  status;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int width = 0;
  bit aborted = 1'b0;
  int zph = 0;

  zbreak #(.REQ_LEN(REQ_LEN), .LOST_INTS(2)) dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg),
    .m1_n(m1_n), .mreq_n(mreq_n), .wr_n(wr_n), .a(a),
    .int_start(int_start), .in_nmi(in_nmi), .din(din),
    .wr_bplo(wr_bplo), .wr_bphi(wr_bphi), .wr_pass(wr_pass), .wr_ctrl(wr_ctrl),
    .brk_req(brk_req), .status(status)
  );

  always #5 fclk = ~fclk;

  // Z80 clock at a quarter of fclk: zpos on phase 0, zneg on phase 2.
  always @(negedge fclk) begin
    zph  = (zph + 1) % 4;
    zpos = (zph == 0);
    zneg = (zph == 2);
  end

  // Pulse monitor: each completed brk_req pulse pops one expected width.
  always @(negedge fclk) begin
    if (brk_req) begin
      width++;
    end else if (width > 0) begin
      if (aborted) begin
        aborted = 1'b0;
      end else begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_pulse: got width %0d, required no pulse", width);
        end else begin
          int w;
          w = exp_q.pop_front();
          if (width != w) begin
            n_errors++;
            $display("FAIL pulse_width: got %0d, required %0d", width, w);
          end
        end
      end
      width = 0;
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic wr_reg(input int sel, input logic [7:0] d);
    @(negedge fclk);
    din = d;
    wr_bplo = (sel == 0); wr_bphi = (sel == 1); wr_pass = (sel == 2); wr_ctrl = (sel == 3);
    @(negedge fclk);
    wr_bplo = 1'b0; wr_bphi = 1'b0; wr_pass = 1'b0; wr_ctrl = 1'b0;
  endtask

  task automatic bus_cycle(input logic [15:0] addr, input logic is_m1);
    @(negedge fclk);
    a = addr; m1_n = ~is_m1; mreq_n = 1'b0;
    repeat (8) @(negedge fclk);
    m1_n = 1'b1; mreq_n = 1'b1;
    repeat (8) @(negedge fclk);
  endtask

  task automatic wait_rise(input string name);
    int k;
    for (k = 0; k < 40 && !brk_req; k++) @(negedge fclk);
    if (!brk_req) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got brk_req 0 after 40 fclk, required 1", name);
    end
  endtask

  task automatic pulse_int();
    @(negedge fclk); int_start = 1'b1;
    @(negedge fclk); int_start = 1'b0;
  endtask

  task automatic set_nmi(input logic v);
    @(negedge fclk); in_nmi = v;
    @(negedge fclk);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic [7:0] exp_status;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{3, 8'h01, 8'h81};
    vecs[1] = '{3, 8'h03, 8'hC1};
`ifdef ZBREAK_WR_EN
    vecs[2] = '{3, 8'h07, 8'hC9};
`else
    vecs[2] = '{3, 8'h07, 8'hC1};
`endif
    vecs[3] = '{3, 8'h00, 8'h00};
    vecs[4] = '{3, 8'h02, 8'h40};

    repeat (3) @(negedge fclk);
    check8("reset_status", status, 8'h00);
    check8("reset_brk_req", {7'd0, brk_req}, 8'h00);
    rst_n = 1'b1;
    @(negedge fclk);

    for (int i = 0; i < 5; i++) begin
      wr_reg(vecs[i].sel, vecs[i].d);
      check8($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
    end

    // Basic hit
    wr_reg(0, 8'h00); wr_reg(1, 8'h80); wr_reg(2, 8'h00); wr_reg(3, 8'h01);
    check8("armed_status", status, 8'h81);
    bus_cycle(16'h7FFF, 1'b1);
    check8("miss_status", status, 8'h81);
    exp_q.push_back(REQ_LEN);
    bus_cycle(16'h8000, 1'b1);
    check8("hit_status", status, 8'hA3);

    // Session without auto re-arm
    set_nmi(1'b1);
    check8("in_session_status", status, 8'hA4);
    set_nmi(1'b0);
    check8("session_end_noauto", status, 8'h20);

    // Pass count with auto re-arm
    wr_reg(2, 8'h02); wr_reg(3, 8'h03);
    check8("pass_armed_status", status, 8'hC1);
    check8("pass_cnt_load", dut.pass_cnt_q, 8'h02);
    bus_cycle(16'h8000, 1'b1);
    check8("pass_cnt_1", dut.pass_cnt_q, 8'h01);
    bus_cycle(16'h8000, 1'b1);
    check8("pass_cnt_0", dut.pass_cnt_q, 8'h00);
    check8("pass_no_hit_yet", status, 8'hC1);
    exp_q.push_back(REQ_LEN);
    bus_cycle(16'h8000, 1'b1);
    check8("pass_hit_status", status, 8'hE3);
    set_nmi(1'b1);
    check8("auto_session_status", status, 8'hE4);
    set_nmi(1'b0);
    check8("auto_rearm_status", status, 8'hE1);
    check8("auto_reload_pass", dut.pass_cnt_q, 8'h02);

    // Suppression inside NMI and on refresh
    in_nmi = 1'b1;
    bus_cycle(16'h8000, 1'b1);
    in_nmi = 1'b0;
    check8("nmi_suppress_pass", dut.pass_cnt_q, 8'h02);
    bus_cycle(16'h8000, 1'b0);
    check8("refresh_pass", dut.pass_cnt_q, 8'h02);
    check8("suppress_status", status, 8'hE1);

    // Lost NMI
    wr_reg(2, 8'h00); wr_reg(3, 8'h00); wr_reg(3, 8'h03);
    check8("lost_armed_pass", dut.pass_cnt_q, 8'h00);
    exp_q.push_back(REQ_LEN);
    bus_cycle(16'h8000, 1'b1);
    check8("lost_hit_status", status, 8'hE3);
    pulse_int();
    check8("one_int_status", status, 8'hE3);
    pulse_int();
    check8("lost_status", status, 8'hF1);

    // Disable during REQ: pulse completes, then IDLE
    exp_q.push_back(REQ_LEN);
    fork
      bus_cycle(16'h8000, 1'b1);
      begin
        wait_rise("disable_req_rise");
        wr_reg(3, 8'h00);
      end
    join
    check8("disable_req_status", status, 8'h30);

    // Reset on the second fclk of the pulse
    wr_reg(3, 8'h01);
    check8("rearm_status", status, 8'h81);
    fork
      bus_cycle(16'h8000, 1'b1);
      begin
        wait_rise("reset_req_rise");
        @(negedge fclk);
        aborted = 1'b1;
        rst_n = 1'b0;
        #1;
        check8("reset_mid_brk_req", {7'd0, brk_req}, 8'h00);
        check8("reset_mid_status", status, 8'h00);
        repeat (3) @(negedge fclk);
        rst_n = 1'b1;
      end
    join
    bus_cycle(16'h8000, 1'b1);
    check8("post_reset_status", status, 8'h00);

    repeat (10) @(negedge fclk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_pulses: got %0d outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
